// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the sequencer and the instruction decoder.
//   seq_state_t  : sequencer control states
//   OP_*         : opcode encodings, OP_LDA..OP_STP = 0..7, OP_LDI = 8
//   is_legal_op  : 1 when the opcode is one of the defined instructions
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC1,
        S_EXEC2,
        S_PAUSE,
        S_HALT
    } seq_state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;

    // The defined opcodes form the contiguous range OP_LDA..OP_LDI.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_LDI);
    endfunction

endpackage

// File: rtl/sequencer_rise_detect.sv
// rise_detect: registered 1-bit rising-edge detector.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : level input, sampled every cycle
//   rise       : d is 1 now and was 0 at the previous clock edge
// RESET_VAL sets the history after reset; 1 means a level already high
// when reset releases is not treated as an edge.
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_p0 <= RESET_VAL;
        else        d_p0 <= d;
    end

    assign rise = d & ~d_p0;

endmodule

// File: rtl/sequencer.sv
// sequencer: control-state generator upstream of the instruction decoder.
//   CLK, RESET_N      : clock, asynchronous active-low reset
//   RUN, STEP_MODE    : run / single-step levels
//   STEP              : rising edge releases one instruction from PAUSE
//   CLEAR             : leaves HALT and clears HALTED/ILLEGAL
//   EXTRA             : decoder request for a second execute cycle (EXEC1 only)
//   MEM_Q             : instruction word, valid during FETCH
//   FETCH/EXEC1/EXEC2 : one-hot state strobes
//   IR, IR_ADDR       : registered opcode and operand fields
//   HALTED, ILLEGAL   : halt status, illegal-opcode cause
//   INSTR_COUNT       : retired instructions, wrapping
module sequencer
    import cpu_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int OPC_W  = 4,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              RUN,
    input  logic              STEP_MODE,
    input  logic              STEP,
    input  logic              CLEAR,
    input  logic              EXTRA,
    input  logic [WORD_W-1:0] MEM_Q,
    output logic              FETCH,
    output logic              EXEC1,
    output logic              EXEC2,
    output logic [OPC_W-1:0]  IR,
    output logic [ADDR_W-1:0] IR_ADDR,
    output logic              HALTED,
    output logic              ILLEGAL,
    output logic [CNT_W-1:0]  INSTR_COUNT
);

    seq_state_t state, state_nxt;
    logic       step_rise;
    logic       retire;
    logic       halt_enter;
    logic       illegal_enter;
    logic       clear_flags;

    rise_detect #(.RESET_VAL(1'b1)) u_step_rise (
        .clk   (CLK),
        .rst_n (RESET_N),
        .d     (STEP),
        .rise  (step_rise)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // EXTRA is only looked at in EXEC1; STP and illegal opcodes take
    // priority over it so a halting instruction never gets an EXEC2.
    always_comb begin
        state_nxt     = state;
        retire        = 1'b0;
        halt_enter    = 1'b0;
        illegal_enter = 1'b0;
        clear_flags   = 1'b0;
        case (state)
            S_IDLE:  if (RUN) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_EXEC1;
            S_EXEC1: begin
                if (IR == OP_STP) begin
                    state_nxt  = S_HALT;
                    halt_enter = 1'b1;
                end else if (!is_legal_op(IR)) begin
                    state_nxt     = S_HALT;
                    halt_enter    = 1'b1;
                    illegal_enter = 1'b1;
                end else if (EXTRA) begin
                    state_nxt = S_EXEC2;
                end else begin
                    retire = 1'b1;
                end
            end
            S_EXEC2: retire = 1'b1;
            S_PAUSE: begin
                if (!RUN)                         state_nxt = S_IDLE;
                else if (step_rise || !STEP_MODE) state_nxt = S_FETCH;
            end
            S_HALT: begin
                if (CLEAR) begin
                    state_nxt   = S_IDLE;
                    clear_flags = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Instruction boundary: stopping wins over pausing.
        if (retire) begin
            if (!RUN)           state_nxt = S_IDLE;
            else if (STEP_MODE) state_nxt = S_PAUSE;
            else                state_nxt = S_FETCH;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            IR      <= '0;
            IR_ADDR <= '0;
        end else if (state == S_FETCH) begin
            IR      <= MEM_Q[WORD_W-1 -: OPC_W];
            IR_ADDR <= MEM_Q[ADDR_W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)    INSTR_COUNT <= '0;
        else if (retire) INSTR_COUNT <= INSTR_COUNT + 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            HALTED  <= 1'b0;
            ILLEGAL <= 1'b0;
        end else if (clear_flags) begin
            HALTED  <= 1'b0;
            ILLEGAL <= 1'b0;
        end else if (halt_enter) begin
            HALTED  <= 1'b1;
            ILLEGAL <= illegal_enter;
        end
    end

    assign FETCH = (state == S_FETCH);
    assign EXEC1 = (state == S_EXEC1);
    assign EXEC2 = (state == S_EXEC2);

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for sequencer with a per-cycle reference model.
module tb_sequencer;

    localparam int CNT_W = 10;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              RUN = 1'b0;
    logic              STEP_MODE = 1'b0;
    logic              STEP = 1'b0;
    logic              CLEAR = 1'b0;
    logic              EXTRA = 1'b0;
    logic [15:0]       MEM_Q = 16'h0000;
    logic              FETCH, EXEC1, EXEC2, HALTED, ILLEGAL;
    logic [3:0]        IR;
    logic [11:0]       IR_ADDR;
    logic [CNT_W-1:0]  INSTR_COUNT;

    int n_tests = 0;
    int n_fail  = 0;

    sequencer #(.WORD_W(16), .OPC_W(4), .ADDR_W(12), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN), .STEP_MODE(STEP_MODE),
        .STEP(STEP), .CLEAR(CLEAR), .EXTRA(EXTRA), .MEM_Q(MEM_Q),
        .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2), .IR(IR), .IR_ADDR(IR_ADDR),
        .HALTED(HALTED), .ILLEGAL(ILLEGAL), .INSTR_COUNT(INSTR_COUNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: an instruction is "in flight" with a cycle index
    // k (0 = fetch cycle, 1 = first execute, 2 = second execute).
    bit               m_busy = 0, m_paused = 0, m_halted = 0, m_illegal = 0;
    int               m_k = 0;
    logic [3:0]       m_ir = '0;
    logic [11:0]      m_addr = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    bit               m_prev_step = 1;

    task automatic m_retire();
        m_cnt  = m_cnt + 1'b1;
        m_busy = 0;
        if (!RUN)           ;
        else if (STEP_MODE) m_paused = 1;
        else begin m_busy = 1; m_k = 0; end
    endtask

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_busy = 0; m_paused = 0; m_halted = 0; m_illegal = 0; m_k = 0;
            m_ir = '0; m_addr = '0; m_cnt = '0; m_prev_step = 1;
        end else begin
            bit rise;
            rise = STEP && !m_prev_step;
            m_prev_step = STEP;
            if (m_halted) begin
                if (CLEAR) begin m_halted = 0; m_illegal = 0; end
            end else if (m_busy) begin
                if (m_k == 0) begin
                    m_ir = MEM_Q[15:12]; m_addr = MEM_Q[11:0]; m_k = 1;
                end else if (m_k == 1) begin
                    if (m_ir == 4'd7)      begin m_busy = 0; m_halted = 1; end
                    else if (m_ir > 4'd8)  begin m_busy = 0; m_halted = 1; m_illegal = 1; end
                    else if (EXTRA)        m_k = 2;
                    else                   m_retire();
                end else begin
                    m_retire();
                end
            end else if (m_paused) begin
                if (!RUN) m_paused = 0;
                else if (rise || !STEP_MODE) begin m_paused = 0; m_busy = 1; m_k = 0; end
            end else if (RUN) begin
                m_busy = 1; m_k = 0;
            end
        end
    end

    wire [30:0] dut_vec = {FETCH, EXEC1, EXEC2, HALTED, ILLEGAL, IR, IR_ADDR, INSTR_COUNT};
    wire [30:0] exp_vec = {m_busy && m_k == 0, m_busy && m_k == 1, m_busy && m_k == 2,
                           m_halted, m_illegal, m_ir, m_addr, m_cnt};

    always @(negedge CLK) begin
        if (RESET_N) begin
            n_tests++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t: got %h expected %h", $time, dut_vec, exp_vec);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        check("reset_strobes", {FETCH, EXEC1, EXEC2}, 3'b000);
        check("reset_flags", {HALTED, ILLEGAL}, 2'b00);
        check("reset_count", INSTR_COUNT, 0);
        RESET_N = 1'b1;
        tick(1);
        check("idle_hold", {FETCH, EXEC1, EXEC2}, 3'b000);

        // ADD with EXTRA: FETCH, EXEC1, EXEC2, FETCH
        MEM_Q = 16'h2005; EXTRA = 1'b1; RUN = 1'b1;
        tick(1); check("add_fetch", {FETCH, EXEC1, EXEC2}, 3'b100);
        tick(1); check("add_exec1", {FETCH, EXEC1, EXEC2, IR, IR_ADDR}, {3'b010, 4'h2, 12'h005});
        tick(1); check("add_exec2", {FETCH, EXEC1, EXEC2, 6'b0, INSTR_COUNT}, {3'b001, 6'b0, 10'd0});
        MEM_Q = 16'h1010; EXTRA = 1'b0;
        tick(1); check("add_retired", {FETCH, 6'b0, INSTR_COUNT}, {1'b1, 6'b0, 10'd1});
        check("model_cnt_add", m_cnt, 1);

        // Two back-to-back STA
        tick(1); check("sta_exec1", {EXEC1, IR, IR_ADDR}, {1'b1, 4'h1, 12'h010});
        tick(3); check("sta_two", {FETCH, 6'b0, INSTR_COUNT}, {1'b1, 6'b0, 10'd3});
        RUN = 1'b0;
        tick(2); check("stop_idle", {FETCH, EXEC1, EXEC2, 6'b0, INSTR_COUNT}, {3'b000, 6'b0, 10'd4});

        // STP with EXTRA -> HALT
        MEM_Q = 16'h7000; EXTRA = 1'b1; RUN = 1'b1;
        tick(3); check("stp_halt", {FETCH, EXEC1, EXEC2, HALTED, ILLEGAL, 6'b0, INSTR_COUNT},
                       {5'b00010, 6'b0, 10'd4});
        RUN = 1'b0; tick(1); RUN = 1'b1; tick(1); STEP = 1'b1; tick(1); STEP = 1'b0; tick(1);
        check("halt_sticky", {FETCH, EXEC1, EXEC2, HALTED}, 4'b0001);
        MEM_Q = 16'hA000; EXTRA = 1'b0; CLEAR = 1'b1;
        tick(1); CLEAR = 1'b0;
        check("clear_stp", {FETCH, EXEC1, EXEC2, HALTED, ILLEGAL}, 5'b00000);

        // Illegal opcode
        tick(3); check("illegal_halt", {HALTED, ILLEGAL, 6'b0, INSTR_COUNT}, {2'b11, 6'b0, 10'd4});
        check("model_illegal", {m_halted, m_illegal}, 2'b11);
        CLEAR = 1'b1; RUN = 1'b0;
        tick(1); CLEAR = 1'b0;
        check("clear_illegal", {HALTED, ILLEGAL}, 2'b00);
        tick(1);

        // Single-step
        STEP_MODE = 1'b1; MEM_Q = 16'h1010; RUN = 1'b1; STEP = 1'b0;
        tick(2); STEP = 1'b1;
        tick(1); check("pause_entry", {FETCH, EXEC1, EXEC2, 6'b0, INSTR_COUNT}, {3'b000, 6'b0, 10'd5});
        tick(2); check("pause_held_step", {FETCH, EXEC1, EXEC2}, 3'b000);
        STEP = 1'b0; tick(1); STEP = 1'b1;
        tick(1); check("step_fetch", {FETCH, EXEC1, EXEC2}, 3'b100);
        tick(2); check("step_repause", {FETCH, EXEC1, EXEC2, 6'b0, INSTR_COUNT}, {3'b000, 6'b0, 10'd6});
        STEP = 1'b0;

        // Counter wrap
        STEP_MODE = 1'b0;
        tick(1 + 2 * 1017);
        check("count_max", {FETCH, 6'b0, INSTR_COUNT}, {1'b1, 6'b0, 10'h3FF});
        check("model_cnt_max", m_cnt, 10'h3FF);
        tick(2); check("count_wrap", {FETCH, 6'b0, INSTR_COUNT}, {1'b1, 6'b0, 10'd0});

        // Asynchronous reset during EXEC2
        tick(2);
        EXTRA = 1'b1;
        tick(2); check("pre_reset_exec2", {EXEC2, 6'b0, INSTR_COUNT}, {1'b1, 6'b0, 10'd1});
        #2 RESET_N = 1'b0;
        #1 check("async_reset", {FETCH, EXEC1, EXEC2, HALTED, ILLEGAL, IR, IR_ADDR, INSTR_COUNT}, 0);
        RUN = 1'b0; EXTRA = 1'b0;
        tick(2);
        RESET_N = 1'b1;
        tick(2); check("post_reset_idle", {FETCH, EXEC1, EXEC2, 6'b0, INSTR_COUNT}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
